// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative multiply/divide, valid/ready on both sides,
// registered result and a pipeline-flush abort.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_operation,
  input  logic [XLEN-1:0] i_operand_1,
  input  logic [XLEN-1:0] i_operand_2,
  input  logic [XLEN-1:0] i_operand_3,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);
  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [4:0] OP_ADD   = 5'h01, OP_SUB  = 5'h02, OP_SLT  = 5'h03,
                         OP_SLTU  = 5'h04, OP_OR   = 5'h05, OP_XOR  = 5'h06,
                         OP_AND   = 5'h07, OP_SLL  = 5'h08, OP_SRL  = 5'h09,
                         OP_SRA   = 5'h0A, OP_MUL  = 5'h10, OP_MULH = 5'h11,
                         OP_MULHU = 5'h12, OP_DIV  = 5'h13, OP_DIVU = 5'h14,
                         OP_REM   = 5'h15, OP_REMU = 5'h16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      op_q;
  logic [XLEN-1:0] hi_q, lo_q, bq_q;
  logic            neg_q;

  logic [XLEN-1:0] a, b, c, sc_res, fin_res, mag_a, mag_b;
  logic [SHW-1:0]  shamt;
  logic            accept, is_iter, is_div_in, signed_in, sa, sb, b_zero;

  assign a     = i_operand_1;
  assign b     = i_operand_2;
  assign c     = i_operand_3;
  assign shamt = b[SHW-1:0];

  always_comb begin
    sc_res = '0;
    case (i_operation)
      OP_ADD:  sc_res = a + b + c;
      OP_SUB:  sc_res = a - b;
      OP_SLT:  sc_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_res = {{(XLEN-1){1'b0}}, a < b};
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_AND:  sc_res = a & b;
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_SRA:  sc_res = $signed(a) >>> shamt;
      default: sc_res = '0;
    endcase
  end

  assign is_iter   = (i_operation >= OP_MUL) && (i_operation <= OP_REMU);
  assign is_div_in = (i_operation >= OP_DIV) && (i_operation <= OP_REMU);
  assign signed_in = (i_operation == OP_MULH) || (i_operation == OP_DIV) ||
                     (i_operation == OP_REM);
  assign sa        = signed_in & a[XLEN-1];
  assign sb        = signed_in & b[XLEN-1];
  assign mag_a     = sa ? -a : a;
  assign mag_b     = sb ? -b : b;
  assign b_zero    = (b == '0);

  // Multiply: {hi,lo} is a right-shifting product, lo starts as the multiplier.
  // Divide: lo shifts dividend bits into hi (remainder) and collects quotient bits.
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod, prod_n;
  logic              is_div_q;

  assign is_div_q = (op_q >= OP_DIV);
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bq_q} : '0);
  assign div_sh   = {hi_q, lo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, bq_q};
  assign prod     = {hi_q, lo_q};
  assign prod_n   = neg_q ? -prod : prod;

  always_comb begin
    fin_res = '0;
    case (op_q)
      OP_MUL:          fin_res = lo_q;
      OP_MULH:         fin_res = prod_n[2*XLEN-1:XLEN];
      OP_MULHU:        fin_res = hi_q;
      OP_DIV, OP_DIVU: fin_res = neg_q ? -lo_q : lo_q;
      OP_REM, OP_REMU: fin_res = neg_q ? -hi_q : hi_q;
      default:         fin_res = '0;
    endcase
  end

  assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q == BUSY);
  assign accept  = i_valid && o_ready && !i_kill;

  always_comb begin
    state_d = state_q;
    if (i_kill) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (accept) state_d = is_iter ? BUSY : DONE;
        BUSY: if (cnt_q == '0) state_d = DONE;
        DONE: if (i_ready) state_d = accept ? (is_iter ? BUSY : DONE) : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_result <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      bq_q     <= '0;
      neg_q    <= 1'b0;
    end else if (!i_kill) begin
      if (accept) begin
        op_q <= i_operation;
        if (is_iter) begin
          cnt_q <= CW'(XLEN);
          hi_q  <= '0;
          lo_q  <= is_div_in ? mag_a : mag_b;
          bq_q  <= is_div_in ? mag_b : mag_a;
          // Divide-by-zero quotient stays all-ones regardless of operand signs
          case (i_operation)
            OP_MULH: neg_q <= sa ^ sb;
            OP_DIV:  neg_q <= (sa ^ sb) & ~b_zero;
            OP_REM:  neg_q <= sa;
            default: neg_q <= 1'b0;
          endcase
        end else begin
          o_result <= sc_res;
        end
      end else if (state_q == BUSY) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
          if (is_div_q) begin
            if (!div_diff[XLEN]) begin
              hi_q <= div_diff[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_q <= div_sh[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_q <= mul_sum[XLEN:1];
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end else begin
          o_result <= fin_res;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (XLEN=32).
module tb_alu_mdu;
  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_operation;
  logic [XLEN-1:0] i_operand_1, i_operand_2, i_operand_3;
  logic            i_kill;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mdu #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_operation(i_operation), .i_operand_1(i_operand_1),
    .i_operand_2(i_operand_2), .i_operand_3(i_operand_3), .i_kill(i_kill),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one request for a single edge; caller guarantees o_ready=1.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, b, c);
    i_valid = 1'b1; i_operation = op;
    i_operand_1 = a; i_operand_2 = b; i_operand_3 = c;
    tick();
    i_valid = 1'b0;
    i_operand_1 = 32'hDEAD_BEEF; i_operand_2 = 32'h1234_5678; i_operand_3 = 32'h0;
  endtask

  // Issue an iterative op, count cycles to o_valid, flag any cycle where
  // o_ready/o_busy were wrong while waiting.
  task automatic run_iter(input logic [4:0] op, input logic [31:0] a, b,
                          output int n, output bit bad);
    issue(op, a, b, 32'h0);
    n = 0; bad = 0;
    while (!o_valid && n < 40) begin
      if (o_ready !== 1'b0 || o_busy !== 1'b1) bad = 1;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_kill = 1'b0; i_ready = 1'b1;
    i_operation = '0; i_operand_1 = '0; i_operand_2 = '0; i_operand_3 = '0;
    #12;
    n_tests++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b busy=%b result=%h, want 0 0 0", o_valid, o_busy, o_result);
    end
    @(negedge i_clk); i_rst_n = 1'b1;
    tick();
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready);
    end
  endtask

  task automatic test_alu();
    logic [4:0]  ops [6] = '{5'h01, 5'h0A, 5'h03, 5'h08, 5'h1F, 5'h0B};
    logic [31:0] as  [6] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h55, 32'h77};
    logic [31:0] bs  [6] = '{32'd7, 32'h24, 32'd1, 32'd33, 32'h66, 32'h1};
    logic [31:0] cs  [6] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] exp [6] = '{32'd13, 32'hF800_0000, 32'd1, 32'd2, 32'd0, 32'd0};
    i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], cs[i]);
      n_tests++;
      if (o_valid !== 1'b1 || o_result !== exp[i]) begin
        n_fail++;
        $display("FAIL alu_op%0h: valid=%b result=%h, want 1 %h", ops[i], o_valid, o_result, exp[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ready_drop = 0;
    i_ready = 1'b1;
    i_valid = 1'b1; i_operation = 5'h02; i_operand_1 = 32'd3; i_operand_2 = 32'd5; i_operand_3 = '0;
    if (o_ready !== 1'b1) ready_drop = 1;
    tick();
    n_tests++;
    if (o_valid !== 1'b1 || o_result !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL b2b_sub: valid=%b result=%h, want 1 fffffffe", o_valid, o_result);
    end
    if (o_ready !== 1'b1) ready_drop = 1;
    i_operation = 5'h04; i_operand_1 = 32'd1; i_operand_2 = 32'hFFFF_FFFF;
    tick();
    n_tests++;
    if (o_valid !== 1'b1 || o_result !== 32'd1) begin
      n_fail++; $display("FAIL b2b_sltu: valid=%b result=%h, want 1 1", o_valid, o_result);
    end
    if (o_ready !== 1'b1) ready_drop = 1;
    i_valid = 1'b0;
    n_tests++;
    if (ready_drop) begin
      n_fail++; $display("FAIL b2b_ready: o_ready dropped, want held 1");
    end
    tick();
  endtask

  task automatic test_mul();
    int n; bit bad;
    i_ready = 1'b1;
    run_iter(5'h11, 32'hFFFF_FFFE, 32'd3, n, bad);
    n_tests++;
    if (n != 33 || o_result !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mulh: latency=%0d result=%h, want 33 ffffffff", n, o_result);
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL mulh_busy: ready/busy wrong while busy, want 0/1"); end
    run_iter(5'h10, 32'hFFFF_FFFE, 32'd3, n, bad);
    n_tests++;
    if (n != 33 || o_result !== 32'hFFFF_FFFA || bad) begin
      n_fail++; $display("FAIL mul: latency=%0d result=%h bad=%b, want 33 fffffffa 0", n, o_result, bad);
    end
    tick();
  endtask

  task automatic test_div();
    logic [4:0]  ops [5] = '{5'h13, 5'h15, 5'h14, 5'h15, 5'h13};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
    int n; bit bad;
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_iter(ops[i], as[i], bs[i], n, bad);
      n_tests++;
      if (n != 33 || o_result !== exp[i] || bad) begin
        n_fail++;
        $display("FAIL div_op%0h_%0d: latency=%0d result=%h bad=%b, want 33 %h 0", ops[i], i, n, o_result, bad, exp[i]);
      end
      tick();
    end
    // Signed divide by zero with a negative dividend: quotient all-ones, remainder = A
    run_iter(5'h13, 32'hFFFF_FFF9, 32'd0, n, bad);
    n_tests++;
    if (o_result !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL div_by0_neg: result=%h want ffffffff", o_result);
    end
    tick();
    run_iter(5'h15, 32'hFFFF_FFF9, 32'd0, n, bad);
    n_tests++;
    if (o_result !== 32'hFFFF_FFF9) begin
      n_fail++; $display("FAIL rem_by0_neg: result=%h want fffffff9", o_result);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n; bit bad; bit unstable = 0;
    i_ready = 1'b0;
    run_iter(5'h14, 32'd100, 32'd7, n, bad);
    n_tests++;
    if (n != 33 || o_result !== 32'd14) begin
      n_fail++; $display("FAIL bp_divu: latency=%0d result=%h, want 33 e", n, o_result);
    end
    for (int i = 0; i < 5; i++) begin
      if (o_valid !== 1'b1 || o_result !== 32'd14 || o_ready !== 1'b0) unstable = 1;
      tick();
    end
    n_tests++;
    if (unstable) begin n_fail++; $display("FAIL bp_hold: result/valid/ready not held, want 14/1/0"); end
    i_ready = 1'b1;
    i_valid = 1'b1; i_operation = 5'h01; i_operand_1 = 32'd1; i_operand_2 = 32'd2; i_operand_3 = 32'd3;
    #1;
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready: got %b want 1", o_ready); end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    n_tests++;
    if (o_valid !== 1'b1 || o_result !== 32'd6) begin
      n_fail++; $display("FAIL bp_add: valid=%b result=%h, want 1 6", o_valid, o_result);
    end
    tick();
  endtask

  task automatic test_abort();
    bit seen = 0;
    i_ready = 1'b1;
    issue(5'h10, 32'd9, 32'd9, 32'd0);
    repeat (9) tick();
    i_kill = 1'b1;
    tick();
    i_kill = 1'b0;
    n_tests++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL kill_state: valid=%b busy=%b ready=%b, want 0 0 1", o_valid, o_busy, o_ready);
    end
    repeat (40) begin
      if (o_valid) seen = 1;
      tick();
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL kill_no_valid: o_valid pulsed after kill, want none"); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    i_ready = 1'b1;
    issue(5'h13, 32'hFFFF_FFF9, 32'd2, 32'd0);
    repeat (5) tick();
    i_rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 32'h0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: valid=%b busy=%b result=%h ready=%b, want 0 0 0 1", o_valid, o_busy, o_result, o_ready);
    end
    #3; i_rst_n = 1'b1;
    repeat (40) begin
      if (o_valid) seen = 1;
      tick();
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL rst_no_valid: result produced after reset, want none"); end
    issue(5'h07, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
    n_tests++;
    if (o_valid !== 1'b1 || o_result !== 32'hF000_F000) begin
      n_fail++; $display("FAIL rst_after_and: valid=%b result=%h, want 1 f000f000", o_valid, o_result);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_mul();
    test_div();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
